// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the FSM state encoding, the writeback-source encoding and the JR opcode helper.
// Imported by the hazard unit top and its sub-modules.
package hazard_unit_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hazard_state_t;

  // Writeback source select carried down the pipe with each instruction
  typedef enum logic [1:0] {
    RS_ALU  = 2'd0,
    RS_NPC  = 2'd1,
    RS_LUI  = 2'd2,
    RS_DMEM = 2'd3
  } regsrc_t;

  // Opcode the decoder presents for JR (R-type funct remapped onto the opcode field)
  localparam logic [5:0] OP_JR = 6'h3e;

  // True when the decode-stage opcode is a register jump
  function automatic logic is_jr(input logic [5:0] op);
    return op == OP_JR;
  endfunction

endpackage

// File: rtl/hazard_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Latency: count visible one cycle after inc; clear wins over inc.
// No backpressure: holds at all-ones once saturated.
module hazard_unit_sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  // Count up until all-ones, then hold; clear takes priority
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline (load-use, JR, dmem wait, imem miss, redirects, halt).
// Latency: enables/flushes are combinational from state+inputs; FSM, watchdog and counters update next edge.
// Backpressure: dmem miss freezes PC..EX/ME and bubbles WB; imem miss stalls PC and bubbles decode.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int DWAIT_MAX = 256,
  parameter int CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [5:0]       opcode_de,
  input  logic [4:0]       rs_de,
  input  logic [4:0]       rt_de,
  input  logic             uses_rt_de,
  input  logic [4:0]       regDst_ex,
  input  logic             regWr_ex,
  input  logic [1:0]       regSrc_ex,
  input  logic             dmemREN_me,
  input  logic             dmemWEN_me,
  input  logic             dhit,
  input  logic             ihit,
  input  logic             branch_tkn_ex,
  input  logic             jump_de,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             flush_em,
  output logic             flush_mw,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] S_RUN    = 2'(RUN);
  localparam logic [1:0] S_DWAIT  = 2'(DWAIT);
  localparam logic [1:0] S_HALTED = 2'(HALTED);

  // Wait counter only needs to reach DWAIT_MAX-1; it saturates there for power-of-two limits
  localparam int WAIT_W = (DWAIT_MAX > 2) ? $clog2(DWAIT_MAX) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DWAIT_MAX - 1);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              mem_busy;
  logic              ld_in_ex;
  logic              rs_hit;
  logic              rt_hit;
  logic              jr_ld;
  logic              load_use;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_inc;
  logic              wait_clr;
  logic              timeout_hit;
  logic              stall_inc;
  logic              flush_inc;

  // Hazard detection terms
  always_comb begin
    mem_busy = (dmemREN_me | dmemWEN_me) & ~dhit;
    // A load in EX whose data only exists after ME; $0 never creates a dependency
    ld_in_ex = regWr_ex && (regSrc_ex == RS_DMEM) && (regDst_ex != 5'd0);
    rs_hit   = ld_in_ex && (regDst_ex == rs_de);
    rt_hit   = ld_in_ex && uses_rt_de && (regDst_ex == rt_de);
    // JR resolves in decode so it needs its target register now; covered by the rs match
    jr_ld    = ld_in_ex && is_jr(opcode_de) && (regDst_ex == rs_de);
    load_use = rs_hit | rt_hit | jr_ld;
  end

  // Prioritised enable/flush generation; reset forces a free-running pipe
  always_comb begin
    pc_en    = 1'b1;
    en_fd    = 1'b1;
    en_de    = 1'b1;
    en_em    = 1'b1;
    en_mw    = 1'b1;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    flush_em = 1'b0;
    flush_mw = 1'b0;
    if (!nRST) begin
      pc_en = 1'b1;
    end else if (state == S_HALTED) begin
      pc_en = 1'b0;
      en_fd = 1'b0;
      en_de = 1'b0;
      en_em = 1'b0;
      en_mw = 1'b0;
    end else if (mem_busy) begin
      // Hold everything up to ME; WB gets a bubble so the stalled access is not retired twice
      pc_en    = 1'b0;
      en_fd    = 1'b0;
      en_de    = 1'b0;
      en_em    = 1'b0;
      flush_mw = 1'b1;
    end else if (branch_tkn_ex) begin
      // Squashing DE also removes any load-use consumer, so no stall is needed
      flush_fd = 1'b1;
      flush_de = 1'b1;
    end else if (load_use) begin
      // One bubble into EX; the load then forwards from ME
      pc_en    = 1'b0;
      en_fd    = 1'b0;
      flush_de = 1'b1;
    end else if (jump_de) begin
      flush_fd = 1'b1;
    end else if (!ihit) begin
      pc_en    = 1'b0;
      flush_fd = 1'b1;
    end
  end

  // Next-state logic: halt wins, DWAIT exits only on a dcache hit
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN: begin
        if (halt_wb) begin
          state_nxt = S_HALTED;
        end else if (mem_busy) begin
          state_nxt = S_DWAIT;
        end
      end
      S_DWAIT: begin
        if (halt_wb) begin
          state_nxt = S_HALTED;
        end else if (dhit) begin
          state_nxt = S_RUN;
        end
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_RUN;
    endcase
  end

  // Counter controls and watchdog condition
  always_comb begin
    wait_inc    = (state == S_DWAIT);
    wait_clr    = (state_nxt != S_DWAIT);
    timeout_hit = (state == S_DWAIT) && !dhit && (wait_cnt >= WAIT_LAST);
    stall_inc   = (state != S_HALTED) && !pc_en;
    flush_inc   = (state != S_HALTED) && flush_fd;
  end

  // FSM state and sticky watchdog flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= S_RUN;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (timeout_hit) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  assign halted = (state == S_HALTED);

  hazard_unit_sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (wait_clr),
    .inc  (wait_inc),
    .cnt  (wait_cnt)
  );

  hazard_unit_sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (1'b0),
    .inc  (stall_inc),
    .cnt  (stall_cnt)
  );

  hazard_unit_sat_counter #(.W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .clr  (1'b0),
    .inc  (flush_inc),
    .cnt  (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model of the stall/flush rules.
module tb_hazard_unit;

  localparam int DWAIT_MAX = 4;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             CLK;
  logic             nRST;
  logic [5:0]       opcode_de;
  logic [4:0]       rs_de, rt_de, regDst_ex;
  logic             uses_rt_de, regWr_ex;
  logic [1:0]       regSrc_ex;
  logic             dmemREN_me, dmemWEN_me, dhit, ihit;
  logic             branch_tkn_ex, jump_de, halt_wb;
  logic             pc_en, en_fd, en_de, en_em, en_mw;
  logic             flush_fd, flush_de, flush_em, flush_mw;
  logic             halted, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  hazard_unit #(.DWAIT_MAX(DWAIT_MAX), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .opcode_de(opcode_de), .rs_de(rs_de), .rt_de(rt_de),
    .uses_rt_de(uses_rt_de), .regDst_ex(regDst_ex), .regWr_ex(regWr_ex), .regSrc_ex(regSrc_ex),
    .dmemREN_me(dmemREN_me), .dmemWEN_me(dmemWEN_me), .dhit(dhit), .ihit(ihit),
    .branch_tkn_ex(branch_tkn_ex), .jump_de(jump_de), .halt_wb(halt_wb),
    .pc_en(pc_en), .en_fd(en_fd), .en_de(en_de), .en_em(en_em), .en_mw(en_mw),
    .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em), .flush_mw(flush_mw),
    .halted(halted), .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 running, 1 waiting on dmem, 2 frozen
  int m_mode;
  int m_wait;
  int m_stall;
  int m_flush;
  bit m_tmo;

  // Snapshot of DUT outputs taken at the last negedge
  logic [8:0]       s_out;
  logic [CNT_W-1:0] s_stall;
  logic             s_halted, s_tmo;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic void model_reset();
    m_mode  = 0;
    m_wait  = 0;
    m_stall = 0;
    m_flush = 0;
    m_tmo   = 1'b0;
  endfunction

  // Expected {pc_en,en_fd,en_de,en_em,en_mw,flush_fd,flush_de,flush_em,flush_mw}
  function automatic logic [8:0] model_out();
    bit busy, lu;
    busy = (dmemREN_me || dmemWEN_me) && !dhit;
    lu   = regWr_ex && (regSrc_ex == 2'b11) && (regDst_ex != 0) &&
           ((regDst_ex == rs_de) || (uses_rt_de && (regDst_ex == rt_de)));
    if (!nRST)              return 9'b11111_0000;
    if (m_mode == 2)        return 9'b00000_0000;
    if (busy)               return 9'b00001_0001;
    if (branch_tkn_ex)      return 9'b11111_1100;
    if (lu)                 return 9'b00111_0100;
    if (jump_de)            return 9'b11111_1000;
    if (!ihit)              return 9'b01111_1000;
    return 9'b11111_0000;
  endfunction

  function automatic void model_update(input logic [8:0] e);
    int nxt;
    bit busy;
    busy = (dmemREN_me || dmemWEN_me) && !dhit;
    if (m_mode != 2) begin
      if (!e[8] && m_stall < CNT_MAX) m_stall++;
      if (e[3]  && m_flush < CNT_MAX) m_flush++;
    end
    if (m_mode == 1 && !dhit && m_wait >= DWAIT_MAX - 1) m_tmo = 1'b1;
    nxt = m_mode;
    if (m_mode != 2) begin
      if (halt_wb)                  nxt = 2;
      else if (m_mode == 0 && busy) nxt = 1;
      else if (m_mode == 1 && dhit) nxt = 0;
    end
    if (m_mode == 1 && nxt == 1) m_wait = (m_wait < DWAIT_MAX - 1) ? m_wait + 1 : m_wait;
    else                         m_wait = 0;
    m_mode = nxt;
  endfunction

  // One cycle: compare at negedge, advance the model at posedge, return just after it
  task automatic step();
    logic [8:0] e;
    @(negedge CLK);
    e        = model_out();
    s_out    = {pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, flush_em, flush_mw};
    s_stall  = stall_cnt;
    s_halted = halted;
    s_tmo    = mem_timeout;
    check("outputs", 32'(s_out), 32'(e));
    check("halted", 32'(s_halted), 32'(m_mode == 2));
    check("mem_timeout", 32'(s_tmo), 32'(m_tmo));
    check("stall_cnt", 32'(s_stall), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    @(posedge CLK);
    if (nRST) model_update(e);
    #1;
  endtask

  task automatic idle();
    opcode_de = 6'h00; rs_de = 5'd0; rt_de = 5'd0; uses_rt_de = 1'b0;
    regDst_ex = 5'd0; regWr_ex = 1'b0; regSrc_ex = 2'b00;
    dmemREN_me = 1'b0; dmemWEN_me = 1'b0; dhit = 1'b1; ihit = 1'b1;
    branch_tkn_ex = 1'b0; jump_de = 1'b0; halt_wb = 1'b0;
  endtask

  task automatic assert_reset();
    nRST = 1'b0;
    model_reset();
  endtask

  task automatic load_in_ex(input logic [4:0] dst);
    regWr_ex = 1'b1; regSrc_ex = 2'b11; regDst_ex = dst;
  endtask

  task automatic rand_inputs();
    opcode_de     = ($urandom_range(0, 5) == 0) ? 6'h3e : 6'($urandom_range(0, 63));
    rs_de         = 5'($urandom_range(0, 3));
    rt_de         = 5'($urandom_range(0, 3));
    uses_rt_de    = 1'($urandom_range(0, 1));
    regDst_ex     = 5'($urandom_range(0, 3));
    regWr_ex      = ($urandom_range(0, 3) != 0);
    regSrc_ex     = 2'($urandom_range(0, 3));
    dmemREN_me    = ($urandom_range(0, 3) == 0);
    dmemWEN_me    = ($urandom_range(0, 6) == 0);
    dhit          = ($urandom_range(0, 2) != 0);
    ihit          = ($urandom_range(0, 5) != 0);
    branch_tkn_ex = ($urandom_range(0, 7) == 0);
    jump_de       = ($urandom_range(0, 7) == 0);
    halt_wb       = ($urandom_range(0, 499) == 0);
  endtask

  initial begin
    idle();
    assert_reset();
    step();
    check("reset_outputs", 32'(s_out), 32'(9'b11111_0000));
    check("reset_stall_cnt", 32'(s_stall), 32'd0);
    nRST = 1'b1;
    step();
    check("idle_outputs", 32'(s_out), 32'(9'b11111_0000));

    // Load-use on rs: one stall cycle
    load_in_ex(5'd2); rs_de = 5'd2; rt_de = 5'd5; uses_rt_de = 1'b1;
    step();
    check("loaduse_outputs", 32'(s_out), 32'(9'b00111_0100));
    idle();
    step();
    check("loaduse_stall_cnt", 32'(s_stall), 32'd1);
    check("loaduse_one_cycle", 32'(s_out), 32'(9'b11111_0000));

    // Load to $0 never stalls
    load_in_ex(5'd0); rs_de = 5'd0;
    step();
    check("ld_r0_pc_en", 32'(s_out[8]), 32'd1);

    // rt match only matters when rt is read
    load_in_ex(5'd3); rs_de = 5'd1; rt_de = 5'd3; uses_rt_de = 1'b0;
    step();
    check("rt_unused_pc_en", 32'(s_out[8]), 32'd1);
    uses_rt_de = 1'b1;
    step();
    check("rt_used_pc_en", 32'(s_out[8]), 32'd0);

    // Three dmem miss cycles, hit on the fourth
    idle(); dmemREN_me = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("dwait_outputs", 32'(s_out), 32'(9'b00001_0001));
    end
    dhit = 1'b1;
    step();
    check("dwait_release", 32'(s_out), 32'(9'b11111_0000));
    check("dwait_stall_cnt", 32'(s_stall), 32'd5);

    // Branch overrides a simultaneous load-use
    idle(); load_in_ex(5'd4); rs_de = 5'd4; branch_tkn_ex = 1'b1;
    step();
    check("branch_over_lu", 32'(s_out), 32'(9'b11111_1100));

    // Watchdog: sets after four wait cycles, sticky through dhit
    idle(); dmemREN_me = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("tmo_not_yet", 32'(s_tmo), 32'd0);
    step();
    check("tmo_set", 32'(s_tmo), 32'd1);
    dhit = 1'b1;
    step();
    idle();
    step();
    check("tmo_sticky", 32'(s_tmo), 32'd1);

    // Async reset in the middle of a dmem stall
    dmemREN_me = 1'b1; dhit = 1'b0;
    step();
    assert_reset();
    step();
    check("rst_mid_outputs", 32'(s_out), 32'(9'b11111_0000));
    check("rst_mid_tmo", 32'(s_tmo), 32'd0);
    nRST = 1'b1;
    step();
    check("rst_mid_rerun", 32'(s_out), 32'(9'b00001_0001));

    // Halt freezes everything until reset
    idle(); halt_wb = 1'b1;
    step();
    halt_wb = 1'b0; ihit = 1'b0; load_in_ex(5'd1); rs_de = 5'd1;
    for (int i = 0; i < 3; i++) step();
    check("halt_outputs", 32'(s_out), 32'd0);
    check("halt_flag", 32'(s_halted), 32'd1);
    assert_reset();
    step();
    check("halt_reset_flag", 32'(s_halted), 32'd0);
    check("halt_reset_stall", 32'(s_stall), 32'd0);
    nRST = 1'b1;
    idle();
    step();

    // Randomized traffic in several reset-separated segments
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 1500; c++) begin
        rand_inputs();
        if ($urandom_range(0, 599) == 0) assert_reset();
        else nRST = 1'b1;
        step();
      end
      idle();
      assert_reset();
      step();
      nRST = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
